// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared pipeline control definitions. ctrl_t is the packed
//                control word produced by decode and carried down the
//                pipeline; CTRL_W is its flattened width for port use.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [1:0] jump;
    } ctrl_t;

    localparam int         CTRL_W   = $bits(ctrl_t);
    localparam logic [1:0] JUMP_JAL = 2'd3;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
// ============================================================================
//  Module      : fwd_mux
//  Description : Operand forwarding select for one source register. The
//                youngest producer (EX/MEM) wins over MEM/WB; register 0 is
//                hard-wired and never forwarded.
//  Ports       : i_en           source is actually read by the instruction
//                i_src          source register index
//                i_rf           register-file read value
//                i_exm_*        EX/MEM producer (regwrite, rd, result)
//                i_mw_*         MEM/WB producer (regwrite, rd, result)
//                o_value        forwarded operand
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_en,
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_rf,
    input  logic              i_exm_regwrite,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic [DATA_W-1:0] i_exm_result,
    input  logic              i_mw_regwrite,
    input  logic [REG_AW-1:0] i_mw_rd,
    input  logic [DATA_W-1:0] i_mw_result,
    output logic [DATA_W-1:0] o_value
);

    logic w_live;
    logic w_exm_hit;
    logic w_mw_hit;

    assign w_live    = i_en && (i_src != '0);
    assign w_exm_hit = w_live && i_exm_regwrite && (i_exm_rd == i_src);
    assign w_mw_hit  = w_live && i_mw_regwrite  && (i_mw_rd  == i_src);

    always_comb begin
        o_value = i_rf;
        if (w_exm_hit) begin
            o_value = i_exm_result;
        end else if (w_mw_hit) begin
            o_value = i_mw_result;
        end
    end

endmodule : fwd_mux

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : Decode->execute pipeline register with RAW hazard handling.
//                With ID_EX_FWD_EN defined, operands are forwarded from
//                EX/MEM and MEM/WB and only a load-use stalls. Without it,
//                operands come straight from the register file and any
//                in-flight producer of a used source stalls the ID stage.
//  Ports       : clk, rst_n            clock, async active-low reset
//                flush                 kill the ID instruction
//                id_*                  decoded instruction + regfile reads
//                exm_*, mw_*           downstream producers
//                stall                 hold PC and IF/ID (combinational)
//                ex_*                  registered EX-stage bundle
//                stall_cnt             saturating stall-cycle counter
//  Config      : ID_EX_FWD_EN  enables the forwarding network
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rt,
    input  logic [DATA_W-1:0] id_read1,
    input  logic [DATA_W-1:0] id_read2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mw_regwrite,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic [DATA_W-1:0] mw_result,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_store,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t             w_id_ctrl;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_op_b;
    logic              w_ex_hit;
    logic              w_load_use;
    logic              w_hz;
    logic              w_capture;

    logic              r_ex_valid;
    ctrl_t             r_ex_ctrl;
    logic [DATA_W-1:0] r_ex_op_a;
    logic [DATA_W-1:0] r_ex_op_b;
    logic [DATA_W-1:0] r_ex_store;
    logic [REG_AW-1:0] r_ex_rd;
    logic [DATA_W-1:0] r_ex_pc;
    logic [DATA_W-1:0] r_ex_imm;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_id_ctrl = ctrl_t'(id_ctrl);

    // The instruction sitting in EX writes a register this ID instruction reads.
    assign w_ex_hit   = (r_ex_rd != '0) &&
                        ((r_ex_rd == id_rs) || (id_use_rt && (r_ex_rd == id_rt)));
    assign w_load_use = r_ex_valid && r_ex_ctrl.mem_read && w_ex_hit;

`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be covered by forwarding: its data arrives
    // from memory one cycle too late.
    assign w_hz = id_valid && w_load_use;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_en           (1'b1),
        .i_src          (id_rs),
        .i_rf           (id_read1),
        .i_exm_regwrite (exm_regwrite),
        .i_exm_rd       (exm_rd),
        .i_exm_result   (exm_result),
        .i_mw_regwrite  (mw_regwrite),
        .i_mw_rd        (mw_rd),
        .i_mw_result    (mw_result),
        .o_value        (w_rs_val)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_en           (id_use_rt),
        .i_src          (id_rt),
        .i_rf           (id_read2),
        .i_exm_regwrite (exm_regwrite),
        .i_exm_rd       (exm_rd),
        .i_exm_result   (exm_result),
        .i_mw_regwrite  (mw_regwrite),
        .i_mw_rd        (mw_rd),
        .i_mw_result    (mw_result),
        .o_value        (w_rt_val)
    );
`else
    logic w_exm_hit;
    logic w_mw_hit;
    logic w_unused_fwd;

    assign w_exm_hit = exm_regwrite && (exm_rd != '0) &&
                       ((exm_rd == id_rs) || (id_use_rt && (exm_rd == id_rt)));
    assign w_mw_hit  = mw_regwrite && (mw_rd != '0) &&
                       ((mw_rd == id_rs) || (id_use_rt && (mw_rd == id_rt)));

    // No bypass: wait until every producer of a used source has retired
    // out of MEM/WB so the register file read is current.
    assign w_hz = id_valid && (w_load_use ||
                               (r_ex_valid && r_ex_ctrl.reg_write && w_ex_hit) ||
                               w_exm_hit || w_mw_hit);

    assign w_rs_val     = id_read1;
    assign w_rt_val     = id_read2;
    assign w_unused_fwd = ^{exm_result, mw_result};
`endif

    // A flushed instruction never executes, so it cannot cause a stall.
    // Gating with rst_n drops stall as soon as reset asserts.
    assign stall     = rst_n && w_hz && !flush;
    assign w_capture = id_valid && !flush && !stall;
    assign w_op_b    = w_id_ctrl.alu_src ? id_imm : w_rt_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= '0;
            r_ex_op_a   <= '0;
            r_ex_op_b   <= '0;
            r_ex_store  <= '0;
            r_ex_rd     <= '0;
            r_ex_pc     <= '0;
            r_ex_imm    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_capture) begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= w_id_ctrl;
                r_ex_op_a  <= w_rs_val;
                r_ex_op_b  <= w_op_b;
                r_ex_store <= w_rt_val;
                r_ex_rd    <= id_rd;
                r_ex_pc    <= id_pc;
                r_ex_imm   <= id_imm;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
                r_ex_op_a  <= '0;
                r_ex_op_b  <= '0;
                r_ex_store <= '0;
                r_ex_rd    <= '0;
                r_ex_pc    <= '0;
                r_ex_imm   <= '0;
            end
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_ctrl   = r_ex_ctrl;
    assign ex_op_a   = r_ex_op_a;
    assign ex_op_b   = r_ex_op_b;
    assign ex_store  = r_ex_store;
    assign ex_rd     = r_ex_rd;
    assign ex_pc     = r_ex_pc;
    assign ex_imm    = r_ex_imm;
    assign stall_cnt = r_stall_cnt;

endmodule : id_ex_stage

`default_nettype wire
